// File: rtl/lut_pkg.sv
// Shared types and helpers for multiport_lut_ram and its read pipeline stage.
package lut_pkg;

    typedef enum logic {
        LUT_INIT = 1'b0,
        LUT_RUN  = 1'b1
    } lut_state_t;

    localparam int unsigned LUT_LAT_MIN = 1;
    localparam int unsigned LUT_LAT_MAX = 2;

    // Only one or two read register stages can be built.
    function automatic bit lut_latency_legal(input int unsigned lat);
        return (lat >= LUT_LAT_MIN) && (lat <= LUT_LAT_MAX);
    endfunction

    // Low bit of channel `chan` within a packed bus of `width`-bit slices.
    function automatic int unsigned lut_slice_lo(input int unsigned chan,
                                                 input int unsigned width);
        return chan * width;
    endfunction

endpackage

// File: rtl/lut_read_pipe.sv
// One per-channel read register stage: valid always follows the input, data is
// captured only for valid requests so an idle channel keeps its last result.
module lut_read_pipe
    import lut_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [DATAWIDTH-1:0] i_data,
    output logic                 o_valid,
    output logic [DATAWIDTH-1:0] o_data
);

    logic                 r_valid;
    logic [DATAWIDTH-1:0] r_data;

    // Register valid every cycle; hold data across idle cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/multiport_lut_ram.sv
// Multi-channel lookup RAM with NPORTS independent read channels, a 1- or
// 2-cycle read pipeline and a post-reset sweeper that fills every entry with
// INIT_VAL. Defining LUT_WRITE_EN adds a runtime write port (RUN state only).
module multiport_lut_ram
    import lut_pkg::*;
#(
    parameter int unsigned          DATAWIDTH = 8,
    parameter int unsigned          DEPTHBITS = 4,
    parameter int unsigned          NPORTS    = 16,
    parameter int unsigned          LATENCY   = 1,
    parameter logic [DATAWIDTH-1:0] INIT_VAL  = '0
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NPORTS-1:0]           i_rd_valid,
    input  logic [NPORTS*DEPTHBITS-1:0] i_rd_addr,
    output logic [NPORTS*DATAWIDTH-1:0] o_rd_data,
    output logic [NPORTS-1:0]           o_rd_data_valid,
    output logic                        o_ready
`ifdef LUT_WRITE_EN
    ,
    input  logic                        i_wr_en,
    input  logic [DEPTHBITS-1:0]        i_wr_addr,
    input  logic [DATAWIDTH-1:0]        i_wr_data
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTHBITS;

    if (!lut_latency_legal(LATENCY)) begin : g_bad_latency
        $error("multiport_lut_ram: LATENCY must be 1 or 2");
    end
    if ((NPORTS < 1) || (NPORTS > 32)) begin : g_bad_nports
        $error("multiport_lut_ram: NPORTS must be in 1..32");
    end

    logic [DATAWIDTH-1:0] r_mem [DEPTH];
    lut_state_t           r_state;
    logic [DEPTHBITS-1:0] r_cnt;

    // Sweep FSM: INIT walks every address once, then RUN until the next reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= LUT_INIT;
            r_cnt   <= '0;
        end else if (r_state == LUT_INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == DEPTHBITS'(DEPTH - 1)) begin
                r_state <= LUT_RUN;
            end
        end
    end

    // Storage: sweeper owns the array during INIT; the write port only in RUN.
    // Reads sample the array combinationally before this edge lands, which
    // gives read-before-write on a same-address collision.
    always_ff @(posedge i_clk) begin
        if (r_state == LUT_INIT) begin
            r_mem[r_cnt] <= INIT_VAL;
        end
`ifdef LUT_WRITE_EN
        else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
`endif
    end

    assign o_ready = (r_state == LUT_RUN);

    for (genvar k = 0; k < NPORTS; k++) begin : g_chan
        logic [DEPTHBITS-1:0] w_addr;
        logic                 w_req;
        logic                 w_s1_valid;
        logic [DATAWIDTH-1:0] w_s1_data;

        assign w_addr = i_rd_addr[lut_slice_lo(k, DEPTHBITS) +: DEPTHBITS];
        // Requests during INIT are dropped rather than queued.
        assign w_req  = i_rd_valid[k] && (r_state == LUT_RUN);

        lut_read_pipe #(
            .DATAWIDTH (DATAWIDTH)
        ) u_stage1 (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_valid (w_req),
            .i_data  (r_mem[w_addr]),
            .o_valid (w_s1_valid),
            .o_data  (w_s1_data)
        );

        if (LATENCY == 2) begin : g_lat2
            logic                 w_s2_valid;
            logic [DATAWIDTH-1:0] w_s2_data;

            lut_read_pipe #(
                .DATAWIDTH (DATAWIDTH)
            ) u_stage2 (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_valid (w_s1_valid),
                .i_data  (w_s1_data),
                .o_valid (w_s2_valid),
                .o_data  (w_s2_data)
            );

            assign o_rd_data_valid[k]                                    = w_s2_valid;
            assign o_rd_data[lut_slice_lo(k, DATAWIDTH) +: DATAWIDTH] = w_s2_data;
        end else begin : g_lat1
            assign o_rd_data_valid[k]                                    = w_s1_valid;
            assign o_rd_data[lut_slice_lo(k, DATAWIDTH) +: DATAWIDTH] = w_s1_data;
        end
    end

endmodule

// File: tb/tb_multiport_lut_ram.sv
// Scoreboard bench for multiport_lut_ram: one LATENCY=1 and one LATENCY=2
// instance share all inputs. Honours LUT_WRITE_EN when it is defined.
module tb_multiport_lut_ram;

    localparam int unsigned N        = 16;
    localparam int unsigned W        = 8;
    localparam int unsigned AB       = 4;
    localparam int unsigned DEPTH    = 16;
    localparam logic [W-1:0] INIT_VAL = 8'h3C;
`ifdef LUT_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0]   v;
        logic [N*W-1:0] d;
    } resp_t;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    rd_valid;
    logic [N*AB-1:0] rd_addr;
    logic            wr_en;
    logic [AB-1:0]   wr_addr;
    logic [W-1:0]    wr_data;
    logic [N*W-1:0]  d1, d2;
    logic [N-1:0]    v1, v2;
    logic            ready1, ready2;

    int    checks = 0;
    int    errors = 0;
    resp_t q1[$];
    resp_t q2[$];
    logic [N*W-1:0] last1, last2;
    logic [W-1:0]   m_mem [DEPTH];
    logic           m_run;
    int             m_cnt;

    multiport_lut_ram #(
        .DATAWIDTH (W), .DEPTHBITS (AB), .NPORTS (N), .LATENCY (1), .INIT_VAL (INIT_VAL)
    ) u_dut_l1 (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_rd_valid      (rd_valid),
        .i_rd_addr       (rd_addr),
        .o_rd_data       (d1),
        .o_rd_data_valid (v1),
        .o_ready         (ready1)
`ifdef LUT_WRITE_EN
        ,
        .i_wr_en         (wr_en),
        .i_wr_addr       (wr_addr),
        .i_wr_data       (wr_data)
`endif
    );

    multiport_lut_ram #(
        .DATAWIDTH (W), .DEPTHBITS (AB), .NPORTS (N), .LATENCY (2), .INIT_VAL (INIT_VAL)
    ) u_dut_l2 (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_rd_valid      (rd_valid),
        .i_rd_addr       (rd_addr),
        .o_rd_data       (d2),
        .o_rd_data_valid (v2),
        .o_ready         (ready2)
`ifdef LUT_WRITE_EN
        ,
        .i_wr_en         (wr_en),
        .i_wr_addr       (wr_addr),
        .i_wr_data       (wr_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Model side of a reset: pipelines empty, outputs zero, sweep restarts.
    task automatic reset_model();
        resp_t bubble;
        q1.delete();
        q2.delete();
        bubble.v = '0;
        bubble.d = '0;
        q2.push_back(bubble);
        last1 = '0;
        last2 = '0;
        m_run = 1'b0;
        m_cnt = 0;
    endtask

    // Called at a falling edge with inputs driven: record the expected response,
    // advance the model, then score both DUTs just after the rising edge.
    task automatic cycle_score(input string tag);
        resp_t e, p;
        logic [N*W-1:0] x;
        e.v = rd_valid & {N{m_run}};
        for (int k = 0; k < N; k++) begin
            e.d[k*W +: W] = m_mem[rd_addr[k*AB +: AB]];
        end
        q1.push_back(e);
        q2.push_back(e);
        if (!m_run) begin
            m_mem[m_cnt] = INIT_VAL;
            if (m_cnt == DEPTH - 1) m_run = 1'b1;
            m_cnt = (m_cnt + 1) % DEPTH;
        end else if (WR_EN && wr_en) begin
            m_mem[wr_addr] = wr_data;
        end
        @(posedge clk);
        #1;
        checks++;
        if (q1.size() == 0) begin
            errors++;
            $display("FAIL %s lat1: scoreboard empty", tag);
        end else begin
            p = q1.pop_front();
            for (int k = 0; k < N; k++) x[k*W +: W] = p.v[k] ? p.d[k*W +: W] : last1[k*W +: W];
            last1 = x;
            if (v1 !== p.v || d1 !== x) begin
                errors++;
                $display("FAIL %s lat1: valid=%h data=%h required valid=%h data=%h",
                         tag, v1, d1, p.v, x);
            end
        end
        checks++;
        if (q2.size() == 0) begin
            errors++;
            $display("FAIL %s lat2: scoreboard empty", tag);
        end else begin
            p = q2.pop_front();
            for (int k = 0; k < N; k++) x[k*W +: W] = p.v[k] ? p.d[k*W +: W] : last2[k*W +: W];
            last2 = x;
            if (v2 !== p.v || d2 !== x) begin
                errors++;
                $display("FAIL %s lat2: valid=%h data=%h required valid=%h data=%h",
                         tag, v2, d2, p.v, x);
            end
        end
        checks++;
        if (ready1 !== m_run || ready2 !== m_run) begin
            errors++;
            $display("FAIL %s ready: got %b/%b required %b", tag, ready1, ready2, m_run);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rd_valid = '0;
        wr_en    = 1'b0;
    endtask

    task automatic test_reset();
        int lowcnt = 0;
        idle_inputs();
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (v1 !== '0 || v2 !== '0 || d1 !== '0 || d2 !== '0 || ready1 !== 1'b0
            || ready2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: v=%h/%h d=%h/%h ready=%b/%b required all zero",
                     v1, v2, d1, d2, ready1, ready2);
        end
        reset_model();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (ready1 !== 1'b0) break;
            lowcnt++;
            cycle_score("init_sweep");
        end
        checks++;
        if (lowcnt != DEPTH) begin
            errors++;
            $display("FAIL ready_low_cycles: got %0d required %0d", lowcnt, DEPTH);
        end
    endtask

    task automatic test_broadcast();
        rd_valid = '1;
        for (int k = 0; k < N; k++) rd_addr[k*AB +: AB] = 4'd5;
        cycle_score("broadcast_addr5");
        idle_inputs();
        repeat (2) cycle_score("broadcast_flush");
    endtask

    task automatic test_collision();
        rd_valid    = 16'h0001;
        rd_addr     = '0;
        rd_addr[AB-1:0] = 4'd3;
        wr_en       = 1'b1;
        wr_addr     = 4'd3;
        wr_data     = 8'hA5;
        cycle_score("collision_same_cycle");
        wr_en = 1'b0;
        cycle_score("collision_reread");
        idle_inputs();
        repeat (2) cycle_score("collision_flush");
    endtask

    task automatic test_pattern();
        rd_valid = 16'h5555;
        for (int k = 0; k < N; k++) rd_addr[k*AB +: AB] = AB'($urandom_range(0, DEPTH - 1));
        cycle_score("pattern_5555");
        rd_valid = '0;
        cycle_score("pattern_gap");
        checks++;
        if (v2 !== 16'h5555) begin
            errors++;
            $display("FAIL pattern_lat2_valid: got %h required %h", v2, 16'h5555);
        end
        rd_valid = 16'hAAAA;
        for (int k = 0; k < N; k++) rd_addr[k*AB +: AB] = AB'(15 - k);
        cycle_score("pattern_aaaa");
        idle_inputs();
        repeat (2) cycle_score("pattern_flush");
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 40; c++) begin
            rd_valid = N'($urandom);
            for (int k = 0; k < N; k++) rd_addr[k*AB +: AB] = AB'($urandom_range(0, DEPTH - 1));
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = AB'($urandom_range(0, DEPTH - 1));
            wr_data = W'($urandom);
            cycle_score("back_to_back");
        end
        idle_inputs();
        repeat (2) cycle_score("b2b_flush");
    endtask

    task automatic test_midreset();
        int lowcnt = 0;
        rd_valid = '1;
        for (int k = 0; k < N; k++) rd_addr[k*AB +: AB] = AB'(k);
        cycle_score("midreset_prime");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (v1 !== '0 || v2 !== '0 || ready1 !== 1'b0 || ready2 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async_clear: v=%h/%h ready=%b/%b required zero",
                     v1, v2, ready1, ready2);
        end
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset_model();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (ready1 !== 1'b0) break;
            lowcnt++;
            rd_valid = (i >= 2 && i <= 10) ? '1 : '0;
            for (int k = 0; k < N; k++) rd_addr[k*AB +: AB] = AB'($urandom_range(0, DEPTH - 1));
            cycle_score("resweep_init_reads");
        end
        checks++;
        if (lowcnt != DEPTH) begin
            errors++;
            $display("FAIL resweep_ready_low_cycles: got %0d required %0d", lowcnt, DEPTH);
        end
        rd_valid = '1;
        for (int k = 0; k < N; k++) rd_addr[k*AB +: AB] = 4'd3;
        cycle_score("resweep_restored");
        idle_inputs();
        repeat (2) cycle_score("resweep_flush");
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_collision();
        test_pattern();
        test_back_to_back();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
